coeff_ram_dp: RTL and testbench

Parametrised polynomial-coefficient store for the SNTRUP757 datapath: one write port, two asynchronous read ports, and a built-in clear sequencer that zeroes every location after reset or on request. It replaces the fixed 12-bit × 1024 single-read distributed RAMs. Its users are the multiplier, the reduction stages and the encode/decode stages, which read two coefficients per cycle and need a known all-zero polynomial before accumulation.

---
 rtl/coeff_ram_pkg.sv | 24 ++
 rtl/coeff_ram_clear_seq.sv | 64 ++++++
 rtl/coeff_ram_dp.sv | 89 ++++++++
 tb/tb_coeff_ram_dp.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/coeff_ram_pkg.sv
// Shared definitions for the polynomial-coefficient store.
// Holds the default coefficient geometry, the address-width helper and
// the clear-sequencer state encoding.
package coeff_ram_pkg;

  localparam int COEFF_WIDTH = 13;
  localparam int N_COEFF     = 757;

  // Smallest address width that can index 'depth' locations (minimum 1 bit).
  function automatic int addr_bits(input int depth);
    int b;
    b = 1;
    while ((1 << b) < depth) begin
      b = b + 1;
    end
    return b;
  endfunction

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

endpackage

// File: rtl/coeff_ram_clear_seq.sv
// Clear sequencer: walks clr_ptr over 0..DEPTH-1 issuing zero-writes.
// Latency: starts on the edge after rst/clear; finishes DEPTH edges later.
// Backpressure: none; busy_o blocks user writes and reads while running.
//
// Ports:
//   clk_i, rst_i (sync, active high), clear_i (one-cycle request)
//   busy_o      - sequence in progress (high during and after rst)
//   zero_we_o   - zero-write strobe for this edge
//   zero_addr_o - location to zero on this edge
module coeff_ram_clear_seq
  import coeff_ram_pkg::*;
#(
  parameter int DEPTH     = N_COEFF,
  parameter int ADDR_BITS = addr_bits(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  output logic                 busy_o,
  output logic                 zero_we_o,
  output logic [ADDR_BITS-1:0] zero_addr_o
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  clr_state_e           state_q;
  logic [ADDR_BITS-1:0] clr_ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // Reset (including mid-sequence) always restarts from location 0.
      state_q   <= CLR_RUN;
      clr_ptr_q <= '0;
    end else begin
      case (state_q)
        CLR_IDLE: begin
          if (clear_i) begin
            state_q   <= CLR_RUN;
            clr_ptr_q <= '0;
          end
        end
        CLR_RUN: begin
          // clear_i is deliberately ignored here: no restart, no extension.
          if (clr_ptr_q == LAST_ADDR) begin
            state_q   <= CLR_IDLE;
            clr_ptr_q <= '0;
          end else begin
            clr_ptr_q <= clr_ptr_q + ADDR_BITS'(1);
          end
        end
        default: begin
          state_q   <= CLR_IDLE;
          clr_ptr_q <= '0;
        end
      endcase
    end
  end

  assign busy_o      = (state_q == CLR_RUN);
  // No array writes while rst is held.
  assign zero_we_o   = busy_o & ~rst_i;
  assign zero_addr_o = clr_ptr_q;

endmodule

// File: rtl/coeff_ram_dp.sv
// Coefficient store: one write port, two read ports, built-in zeroing.
// Latency: write 1 edge; read 0 cycles (1 cycle with COEFF_RAM_DP_OUTREG_EN).
// Backpressure: writes dropped (write_accept=0) while busy, on clear or out of range.
//
// Ports:
//   clk, rst (sync, active high), clear (one-cycle zero-all request)
//   busy                         - clear sequence in progress
//   write_enable/_address, input_data, write_accept - write port
//   read_address_a/b, output_data_a/b               - read ports, 0 when
//                                  busy or address >= DEPTH
// Build option: define COEFF_RAM_DP_OUTREG_EN to register both read outputs.
module coeff_ram_dp
  import coeff_ram_pkg::*;
#(
  parameter int WIDTH     = COEFF_WIDTH,
  parameter int DEPTH     = N_COEFF,
  parameter int ADDR_BITS = addr_bits(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  output logic                 busy,
  input  logic                 write_enable,
  input  logic [ADDR_BITS-1:0] write_address,
  input  logic [WIDTH-1:0]     input_data,
  output logic                 write_accept,
  input  logic [ADDR_BITS-1:0] read_address_a,
  input  logic [ADDR_BITS-1:0] read_address_b,
  output logic [WIDTH-1:0]     output_data_a,
  output logic [WIDTH-1:0]     output_data_b
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  logic                 zero_we;
  logic [ADDR_BITS-1:0] zero_addr;
  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [WIDTH-1:0]     rd_a, rd_b;

  coeff_ram_clear_seq #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_clear_seq (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear),
    .busy_o      (busy),
    .zero_we_o   (zero_we),
    .zero_addr_o (zero_addr)
  );

  // busy is a registered state decode, so write_accept is stable before the edge.
  assign write_accept = write_enable & ~busy & ~clear & (write_address <= LAST_ADDR);

  // Contents are never reset; the sequencer zero-write has priority.
  always_ff @(posedge clk) begin
    if (zero_we) begin
      mem_q[zero_addr] <= '0;
    end else if (write_accept && !rst) begin
      mem_q[write_address] <= input_data;
    end
  end

  assign rd_a = (busy || (read_address_a > LAST_ADDR)) ? '0 : mem_q[read_address_a];
  assign rd_b = (busy || (read_address_b > LAST_ADDR)) ? '0 : mem_q[read_address_b];

`ifdef COEFF_RAM_DP_OUTREG_EN
  logic [WIDTH-1:0] out_a_q, out_b_q;

  // Zero-forcing uses busy/address at the sample edge; a same-edge write
  // is not yet visible, so read-during-write yields the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_a_q <= '0;
      out_b_q <= '0;
    end else begin
      out_a_q <= rd_a;
      out_b_q <= rd_b;
    end
  end

  assign output_data_a = out_a_q;
  assign output_data_b = out_b_q;
`else
  assign output_data_a = rd_a;
  assign output_data_b = rd_b;
`endif

endmodule

// File: tb/tb_coeff_ram_dp.sv
// Bench for coeff_ram_dp: directed scenarios with literal expectations plus
// an array/countdown model compared against the outputs every cycle.
// Define COEFF_RAM_DP_OUTREG_EN for the registered-output build.
module tb_coeff_ram_dp;

  localparam int W  = 13;
  localparam int D  = 757;
  localparam int AB = 10;
`ifdef COEFF_RAM_DP_OUTREG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          busy;
  logic          write_enable = 1'b0;
  logic [AB-1:0] write_address = '0;
  logic [W-1:0]  input_data = '0;
  logic          write_accept;
  logic [AB-1:0] read_address_a = '0;
  logic [AB-1:0] read_address_b = '0;
  logic [W-1:0]  output_data_a;
  logic [W-1:0]  output_data_b;

  always #5 clk = ~clk;

  coeff_ram_dp dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .busy           (busy),
    .write_enable   (write_enable),
    .write_address  (write_address),
    .input_data     (input_data),
    .write_accept   (write_accept),
    .read_address_a (read_address_a),
    .read_address_b (read_address_b),
    .output_data_a  (output_data_a),
    .output_data_b  (output_data_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // busy_left = number of further edges the store stays unavailable.
  logic [W-1:0] model [D];
  int           busy_left = 0;
  bit           model_on = 1'b0;
  logic [W-1:0] exp_reg_a, exp_reg_b;

  function automatic logic [W-1:0] exp_rd(input logic [AB-1:0] a);
    if (busy_left > 0 || int'(a) >= D) return '0;
    return model[a];
  endfunction

  always @(posedge clk) begin
    exp_reg_a = rst ? '0 : exp_rd(read_address_a);
    exp_reg_b = rst ? '0 : exp_rd(read_address_b);
    if (rst) begin
      model_on  = 1'b1;
      busy_left = D;
      for (int i = 0; i < D; i++) model[i] = '0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (clear) begin
      busy_left = D;
      for (int i = 0; i < D; i++) model[i] = '0;
    end else if (write_enable && int'(write_address) < D) begin
      model[write_address] = input_data;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      logic eb, ew;
      eb = (busy_left > 0);
      ew = write_enable && !eb && !clear && (int'(write_address) < D);
      chk("model_busy", busy, eb);
      chk("model_write_accept", write_accept, ew);
`ifdef COEFF_RAM_DP_OUTREG_EN
      chk("model_out_a", output_data_a, exp_reg_a);
      chk("model_out_b", output_data_b, exp_reg_b);
`else
      chk("model_out_a", output_data_a, exp_rd(read_address_a));
      chk("model_out_b", output_data_b, exp_rd(read_address_b));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait until outputs reflect the currently driven read addresses.
  task automatic samp();
    if (LAT == 1) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int addrs [3];
    addrs = '{0, 378, 756};

    // Reset release
    repeat (3) step();
    @(negedge clk);
    chk("rst_out_a_zero", output_data_a, 0);
    chk("rst_out_b_zero", output_data_b, 0);
    chk("rst_busy_high", busy, 1);
    step();
    rst = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      step();
      n++;
    end
    chk("rst_release_busy_edges", n, 757);
    foreach (addrs[k]) begin
      read_address_a = AB'(addrs[k]);
      read_address_b = AB'(addrs[k]);
      samp();
      chk("post_rst_read_a", output_data_a, 0);
      chk("post_rst_read_b", output_data_b, 0);
      step();
    end

    // Write / read, including read-during-write
    write_enable = 1'b1; write_address = 10'd756; input_data = 13'h0001;
    step();
    write_address = 10'd5; input_data = 13'h1ABC;
    read_address_a = 10'd5; read_address_b = 10'd756;
    samp();
    chk("rdw_old_value", output_data_a, 0);
    chk("portb_756", output_data_b, 13'h0001);
    step();
    write_enable = 1'b0;
    samp();
    chk("rdw_new_value", output_data_a, 13'h1ABC);

    // Out of range
    step();
    write_enable = 1'b1; write_address = 10'd757; input_data = 13'h1FFF;
    @(negedge clk);
    chk("oor_write_accept", write_accept, 0);
    step();
    write_enable = 1'b0;
    read_address_a = 10'd1000; read_address_b = 10'd1000;
    samp();
    chk("oor_read_a", output_data_a, 0);
    chk("oor_read_b", output_data_b, 0);
    step();
    read_address_a = 10'd756; read_address_b = 10'd5;
    samp();
    chk("oor_no_alias_756", output_data_a, 13'h0001);
    chk("oor_no_alias_5", output_data_b, 13'h1ABC);

    // Fill with index, then clear with a colliding write
    step();
    for (int i = 0; i < D; i++) begin
      write_enable = 1'b1; write_address = AB'(i); input_data = W'(i);
      step();
    end
    write_enable = 1'b0;
    read_address_a = 10'd300; read_address_b = 10'd10;
    samp();
    chk("fill_300", output_data_a, 300);
    chk("fill_10", output_data_b, 10);
    step();
    clear = 1'b1; write_enable = 1'b1; write_address = 10'd10; input_data = 13'h0555;
    @(negedge clk);
    chk("clear_blocks_write", write_accept, 0);
    step();
    clear = 1'b0; write_enable = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      clear = (n == 100);
      step();
      n++;
    end
    clear = 1'b0;
    chk("clear_busy_cycles", n, 757);
    for (int a = 0; a < D; a++) begin
      read_address_a = AB'(a);
      read_address_b = AB'(D - 1 - a);
      samp();
      chk("sweep_zero_a", output_data_a, 0);
      chk("sweep_zero_b", output_data_b, 0);
      step();
    end

    // Reset mid-clear at clr_ptr = 400
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (400) step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      write_enable = 1'b1; write_address = 10'd20; input_data = 13'h0077;
      @(negedge clk);
      chk("busy_write_dropped", write_accept, 0);
      step();
      n++;
    end
    write_enable = 1'b0;
    chk("midclear_restart_edges", n, 757);
    read_address_a = 10'd20; read_address_b = 10'd0;
    samp();
    chk("busy_write_not_stored", output_data_a, 0);
    chk("midclear_loc0_zero", output_data_b, 0);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
